// File: rtl/snn_interfaces_pkg.sv
// Shared types and default dimensions for the SNN feature-map memory blocks.
package snn_interfaces_pkg;

  localparam int DEFAULT_COORD_BITS   = 8;
  localparam int DEFAULT_IMG_WIDTH    = 32;
  localparam int DEFAULT_IMG_HEIGHT   = 32;
  localparam int DEFAULT_OUT_CHANNELS = 4;
  localparam int DEFAULT_NEURON_BITS  = 8;
  localparam int DEFAULT_WORD_BITS    = DEFAULT_OUT_CHANNELS * DEFAULT_NEURON_BITS;

  typedef struct packed {
    logic [DEFAULT_COORD_BITS-1:0] x;
    logic [DEFAULT_COORD_BITS-1:0] y;
  } vec2_t;

  typedef logic [DEFAULT_WORD_BITS-1:0] fm_word_t;

  typedef enum logic {
    FM_CLEAR = 1'b0,
    FM_RUN   = 1'b1
  } fm_state_t;

endpackage

// File: rtl/feature_map_mem_arbiter_if.sv
// Client-side bus of the feature-map arbiter: A/B read and write ports plus clear/status.
interface feature_map_mem_arbiter_if
  import snn_interfaces_pkg::*;
#(
  parameter int W = DEFAULT_WORD_BITS
);

  logic         a_read_req;
  vec2_t        a_coord_get;
  logic [W-1:0] a_read_data;
  logic         a_read_valid;
  logic         a_write_req;
  vec2_t        a_coord_wtr;
  logic [W-1:0] a_write_data;

  logic         b_read_req;
  vec2_t        b_read_coord;
  logic         b_read_gnt;
  logic [W-1:0] b_read_data;
  logic         b_read_valid;
  logic         b_write_req;
  vec2_t        b_write_coord;
  logic [W-1:0] b_write_data;
  logic         b_write_gnt;

  logic         clear_req;
  logic         ready;
  logic         coord_err;

  modport master (
    output a_read_req, a_coord_get, a_write_req, a_coord_wtr, a_write_data,
    output b_read_req, b_read_coord, b_write_req, b_write_coord, b_write_data,
    output clear_req,
    input  a_read_data, a_read_valid,
    input  b_read_gnt, b_read_data, b_read_valid, b_write_gnt,
    input  ready, coord_err
  );

  modport slave (
    input  a_read_req, a_coord_get, a_write_req, a_coord_wtr, a_write_data,
    input  b_read_req, b_read_coord, b_write_req, b_write_coord, b_write_data,
    input  clear_req,
    output a_read_data, a_read_valid,
    output b_read_gnt, b_read_data, b_read_valid, b_write_gnt,
    output ready, coord_err
  );

endinterface

// File: rtl/feature_map_mem_arbiter_bram.sv
// Simple dual-port RAM (one write, one registered read), written to map onto block RAM.
module fm_dual_port_bram #(
  parameter int DEPTH = 1024,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array and read register have no reset so they infer block RAM; the owner clears contents by sweeping writes.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/feature_map_mem_arbiter.sv
// Feature-map BRAM owner: strict-priority A/B arbitration, write-first forwarding, clear sweep.
module feature_map_mem_arbiter
  import snn_interfaces_pkg::*;
#(
  parameter int COORD_BITS      = DEFAULT_COORD_BITS,
  parameter int IMG_WIDTH       = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT      = DEFAULT_IMG_HEIGHT,
  parameter int OUT_CHANNELS    = DEFAULT_OUT_CHANNELS,
  parameter int BITS_PER_NEURON = DEFAULT_NEURON_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  feature_map_mem_arbiter_if.slave  bus
);

  localparam int W     = OUT_CHANNELS * BITS_PER_NEURON;
  localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0]       LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [COORD_BITS:0] X_LIM     = (COORD_BITS + 1)'(IMG_WIDTH);
  localparam logic [COORD_BITS:0] Y_LIM     = (COORD_BITS + 1)'(IMG_HEIGHT);

  function automatic logic coord_ok(input vec2_t c);
    return ({1'b0, c.x} < X_LIM) && ({1'b0, c.y} < Y_LIM);
  endfunction

  function automatic logic [AW-1:0] coord_addr(input vec2_t c);
    return AW'(c.y) * AW'(IMG_WIDTH) + AW'(c.x);
  endfunction

  fm_state_t     state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          run;

  assign run = (state_q == FM_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FM_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      // NOTE: every clocked state uses <= so all registers update from the same pre-edge values.
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      FM_CLEAR: begin
        if (bus.clear_req) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == LAST_ADDR) begin
          state_d   = FM_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      FM_RUN: begin
        if (bus.clear_req) begin
          state_d   = FM_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = FM_CLEAR;
    endcase
  end

  // Arbitration is purely a function of the requests, so A never waits on B.
  logic          rd_a, rd_b, rd_any, rd_ok;
  logic          wr_a, wr_b, wr_any, wr_ok;
  vec2_t         rd_coord, wr_coord;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  wr_data;

  assign rd_a     = run & bus.a_read_req;
  assign rd_b     = run & bus.b_read_req & ~bus.a_read_req;
  assign rd_any   = rd_a | rd_b;
  assign rd_coord = bus.a_read_req ? bus.a_coord_get : bus.b_read_coord;
  assign rd_ok    = coord_ok(rd_coord);
  assign rd_addr  = coord_addr(rd_coord);

  assign wr_a     = run & bus.a_write_req;
  assign wr_b     = run & bus.b_write_req & ~bus.a_write_req;
  assign wr_any   = wr_a | wr_b;
  assign wr_coord = bus.a_write_req ? bus.a_coord_wtr : bus.b_write_coord;
  assign wr_data  = bus.a_write_req ? bus.a_write_data : bus.b_write_data;
  assign wr_ok    = coord_ok(wr_coord);
  assign wr_addr  = coord_addr(wr_coord);

  assign bus.b_read_gnt  = rd_b;
  assign bus.b_write_gnt = wr_b;

  logic          mem_we, mem_re, fwd;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata, mem_rdata;

  // While clearing, the sweep counter owns the write port outright.
  assign mem_we    = ~run | (wr_any & wr_ok);
  assign mem_waddr = run ? wr_addr : clr_cnt_q;
  assign mem_wdata = run ? wr_data : '0;
  assign mem_re    = rd_any & rd_ok;
  assign fwd       = mem_re & wr_any & wr_ok & (rd_addr == wr_addr);

  fm_dual_port_bram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_bram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_addr_sel()),
    .rdata (mem_rdata)
  );

  function automatic logic [AW-1:0] mem_addr_sel();
    return rd_addr;
  endfunction

  logic         a_valid_q, b_valid_q, zero_q, fwd_q, err_q;
  logic [W-1:0] fwd_data_q, word;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      zero_q    <= 1'b0;
      fwd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      a_valid_q <= rd_a;
      b_valid_q <= rd_b;
      zero_q    <= ~rd_ok;
      fwd_q     <= fwd;
      err_q     <= err_q | (rd_any & ~rd_ok) | (wr_any & ~wr_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (fwd) fwd_data_q <= wr_data;
  end

  assign word = zero_q ? '0 : (fwd_q ? fwd_data_q : mem_rdata);

  assign bus.a_read_valid = a_valid_q;
  assign bus.b_read_valid = b_valid_q;
  assign bus.a_read_data  = a_valid_q ? word : '0;
  assign bus.b_read_data  = b_valid_q ? word : '0;
  assign bus.ready        = run;
  assign bus.coord_err    = err_q;

endmodule

// File: tb/tb_feature_map_mem_arbiter.sv
// Directed plus randomized bench for feature_map_mem_arbiter against a behavioural memory model.
module tb_feature_map_mem_arbiter;
  import snn_interfaces_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  feature_map_mem_arbiter_if #(.W(DEFAULT_WORD_BITS)) bus ();

  feature_map_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fm_word_t mdl [1024];
  logic     merr;
  int       n;
  logic     gnt_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec2_t xy(input int x, input int y);
    vec2_t c;
    c.x = 8'(x);
    c.y = 8'(y);
    return c;
  endfunction

  task automatic idle();
    bus.a_read_req    = 1'b0;
    bus.a_write_req   = 1'b0;
    bus.b_read_req    = 1'b0;
    bus.b_write_req   = 1'b0;
    bus.clear_req     = 1'b0;
    bus.a_coord_get   = xy(0, 0);
    bus.a_coord_wtr   = xy(0, 0);
    bus.b_read_coord  = xy(0, 0);
    bus.b_write_coord = xy(0, 0);
    bus.a_write_data  = '0;
    bus.b_write_data  = '0;
  endtask

  task automatic a_rd(input int x, input int y);
    bus.a_read_req  = 1'b1;
    bus.a_coord_get = xy(x, y);
  endtask

  task automatic a_wr(input int x, input int y, input fm_word_t d);
    bus.a_write_req  = 1'b1;
    bus.a_coord_wtr  = xy(x, y);
    bus.a_write_data = d;
  endtask

  // Counts edges until ready, noting any B grant seen while waiting.
  task automatic wait_ready(output int cnt, output logic seen);
    cnt  = 0;
    seen = 1'b0;
    while (!bus.ready && cnt < 1100) begin
      seen = seen | bus.b_read_gnt | bus.b_write_gnt;
      tick();
      cnt++;
    end
  endtask

  function automatic logic in_fm(input vec2_t c);
    return (c.x < 8'd32) && (c.y < 8'd32);
  endfunction

  function automatic int idx(input vec2_t c);
    return int'(c.y) * 32 + int'(c.x);
  endfunction

  function automatic vec2_t rnd_coord();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return xy($urandom_range(30, 33), $urandom_range(30, 33));
    if (s <= 2) return xy($urandom_range(0, 31), $urandom_range(0, 31));
    return xy($urandom_range(0, 3), $urandom_range(0, 3));
  endfunction

  // One randomized cycle scored against the model: priority, forwarding, validity, sticky error.
  task automatic rand_cycle();
    logic     ar, aw, br, bw, bgr, bgw, rsv, wsv;
    vec2_t    rc, wc;
    fm_word_t wd, exp_d;
    ar = 1'($urandom_range(0, 1));
    aw = 1'($urandom_range(0, 1));
    br = 1'($urandom_range(0, 1));
    bw = 1'($urandom_range(0, 1));
    bus.a_read_req    = ar;
    bus.a_write_req   = aw;
    bus.b_read_req    = br;
    bus.b_write_req   = bw;
    bus.a_coord_get   = rnd_coord();
    bus.a_coord_wtr   = rnd_coord();
    bus.b_read_coord  = rnd_coord();
    bus.b_write_coord = rnd_coord();
    bus.a_write_data  = $urandom;
    bus.b_write_data  = $urandom;
    #2;
    bgr = br && !ar;
    bgw = bw && !aw;
    check("rnd_b_read_gnt", bus.b_read_gnt, bgr);
    check("rnd_b_write_gnt", bus.b_write_gnt, bgw);
    rsv = ar || bgr;
    wsv = aw || bgw;
    rc  = ar ? bus.a_coord_get : bus.b_read_coord;
    wc  = aw ? bus.a_coord_wtr : bus.b_write_coord;
    wd  = aw ? bus.a_write_data : bus.b_write_data;
    if (!in_fm(rc)) exp_d = '0;
    else if (wsv && in_fm(wc) && rc == wc) exp_d = wd;
    else exp_d = mdl[idx(rc)];
    if (wsv && in_fm(wc)) mdl[idx(wc)] = wd;
    if ((rsv && !in_fm(rc)) || (wsv && !in_fm(wc))) merr = 1'b1;
    tick();
    check("rnd_a_read_valid", bus.a_read_valid, ar);
    check("rnd_b_read_valid", bus.b_read_valid, bgr);
    if (ar)  check("rnd_a_read_data", bus.a_read_data, exp_d);
    if (bgr) check("rnd_b_read_data", bus.b_read_data, exp_d);
    check("rnd_coord_err", bus.coord_err, merr);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;
    bus.a_read_req = 1'b1;
    tick();
    tick();
    check("rst_ready", bus.ready, 0);
    check("rst_a_read_valid", bus.a_read_valid, 0);
    check("rst_b_read_valid", bus.b_read_valid, 0);
    check("rst_a_read_data", bus.a_read_data, 0);
    check("rst_coord_err", bus.coord_err, 0);
    idle();
    rst = 1'b0;

    bus.b_read_req = 1'b1;
    wait_ready(n, gnt_seen);
    check("init_clear_cycles", n, 1024);
    check("init_clear_no_gnt", gnt_seen, 0);
    idle();

    a_rd(5, 7);
    tick();
    check("cleared_valid", bus.a_read_valid, 1);
    check("cleared_data", bus.a_read_data, 0);
    idle();
    tick();
    check("valid_pulse", bus.a_read_valid, 0);

    a_wr(3, 4, 32'h1122_3344);
    tick();
    idle();
    a_rd(3, 4);
    tick();
    check("rw_valid", bus.a_read_valid, 1);
    check("rw_data", bus.a_read_data, 32'h1122_3344);
    idle();

    a_wr(0, 0, 32'h0000_00AA);
    a_rd(0, 0);
    tick();
    check("fwd_data", bus.a_read_data, 32'h0000_00AA);
    idle();

    bus.b_write_req   = 1'b1;
    bus.b_write_coord = xy(2, 2);
    bus.b_write_data  = 32'h0000_0055;
    #2;
    check("b_wr_gnt_alone", bus.b_write_gnt, 1);
    tick();
    idle();

    a_rd(1, 1);
    bus.b_read_req   = 1'b1;
    bus.b_read_coord = xy(2, 2);
    #2;
    check("b_rd_gnt_blocked", bus.b_read_gnt, 0);
    tick();
    check("arb_a_valid", bus.a_read_valid, 1);
    check("arb_b_no_valid", bus.b_read_valid, 0);
    bus.a_read_req = 1'b0;
    #2;
    check("b_rd_gnt_idle_a", bus.b_read_gnt, 1);
    tick();
    check("b_rd_valid", bus.b_read_valid, 1);
    check("b_rd_data", bus.b_read_data, 32'h0000_0055);
    idle();

    a_wr(6, 6, 32'h0000_00A6);
    bus.b_write_req   = 1'b1;
    bus.b_write_coord = xy(6, 6);
    bus.b_write_data  = 32'h0000_00B6;
    #2;
    check("b_wr_gnt_blocked", bus.b_write_gnt, 0);
    tick();
    idle();
    a_rd(6, 6);
    tick();
    check("wr_arb_a_wins", bus.a_read_data, 32'h0000_00A6);
    idle();

    a_rd(32, 0);
    tick();
    check("bad_rd_valid", bus.a_read_valid, 1);
    check("bad_rd_data", bus.a_read_data, 0);
    check("bad_rd_err", bus.coord_err, 1);
    idle();
    a_wr(32, 0, 32'h0000_DEAD);
    tick();
    idle();
    a_rd(0, 1);
    tick();
    check("bad_wr_no_wrap", bus.a_read_data, 0);
    idle();
    a_rd(0, 0);
    tick();
    check("bad_mem_unchanged", bus.a_read_data, 32'h0000_00AA);
    check("err_sticky", bus.coord_err, 1);
    idle();

    a_wr(31, 31, 32'h3131_3131);
    tick();
    idle();
    a_rd(31, 31);
    tick();
    check("corner_data", bus.a_read_data, 32'h3131_3131);
    idle();

    a_wr(9, 9, 32'h0000_00FF);
    tick();
    idle();
    a_rd(9, 9);
    tick();
    check("pre_clear_data", bus.a_read_data, 32'h0000_00FF);
    idle();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    check("clear_ready_drop", bus.ready, 0);
    bus.b_read_req  = 1'b1;
    bus.b_write_req = 1'b1;
    wait_ready(n, gnt_seen);
    check("clear_cycles", n, 1024);
    check("clear_no_gnt", gnt_seen, 0);
    idle();
    a_rd(9, 9);
    tick();
    check("post_clear_data", bus.a_read_data, 0);
    check("err_survives_clear", bus.coord_err, 1);
    idle();

    a_rd(3, 4);
    rst = 1'b1;
    tick();
    check("midrun_rst_valid", bus.a_read_valid, 0);
    check("midrun_rst_ready", bus.ready, 0);
    check("midrun_rst_err", bus.coord_err, 0);
    rst = 1'b0;
    idle();
    wait_ready(n, gnt_seen);
    check("rst_clear_cycles", n, 1024);

    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    merr = 1'b0;
    for (int i = 0; i < 400; i++) rand_cycle();
    idle();
    tick();
    check("final_idle_valid", bus.a_read_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
